// File: rtl/data_memory_hs.sv
// Byte-addressed RV32 data memory with valid/ready request/response handshake,
// funct3 load/store sizing, configurable read latency and error reporting.
module data_memory_hs #(
    parameter int unsigned DEPTH_WORDS    = 64,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    // WAIT holds for READ_LATENCY-1 cycles; the counter runs down to zero.
    localparam logic [1:0] WAIT_INIT =
        (READ_LATENCY > 32'd1) ? 2'(READ_LATENCY - 32'd2) : 2'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_cnt;
    logic [1:0]  w_cnt_next;
    logic [31:0] r_rdata;
    logic        r_error;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_oor;
    logic          w_size_err;
    logic          w_err;
    logic          w_write_en;
    logic [3:0]    w_wmask;
    logic [31:0]   w_wdata;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;
    logic [31:0]   w_rdata_next;

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_error = r_error;

    assign w_accept   = req_valid & (r_state == S_IDLE);
    assign w_idx      = req_addr[AW+1:2];
    assign w_lane     = req_addr[1:0];
    assign w_oor      = |req_addr[31:AW+2];
    assign w_word     = r_mem[w_idx];
    assign w_byte     = w_word[{w_lane, 3'b000} +: 8];
    assign w_half     = w_word[{w_lane[1], 4'b0000} +: 16];
    assign w_write_en = w_accept & req_write & ~w_err;

    // Request legality: size/alignment per funct3, range, and store-only codes.
    always_comb begin
        w_size_err = 1'b0;
        case (req_funct3)
            3'd0, 3'd4: w_size_err = 1'b0;
            3'd1, 3'd5: w_size_err = w_lane[0];
            3'd2:       w_size_err = (w_lane != 2'd0);
            default:    w_size_err = 1'b1;
        endcase
        // Stores only define funct3 0..2; bit 2 set means an unsigned/illegal code.
        w_err = w_oor | w_size_err | (req_write & req_funct3[2]);
    end

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        w_wmask = 4'b0000;
        w_wdata = 32'd0;
        case (req_funct3[1:0])
            2'd0: begin
                w_wmask = 4'b0001 << w_lane;
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                w_wmask = 4'b0011 << w_lane;
                w_wdata = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                w_wmask = 4'b1111;
                w_wdata = req_wdata;
            end
            default: begin
                w_wmask = 4'b0000;
                w_wdata = 32'd0;
            end
        endcase
    end

    // Load extraction and sign/zero extension; stores and errors return zero.
    always_comb begin
        w_load = 32'd0;
        case (req_funct3)
            3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_load = {24'd0, w_byte};
            3'd1:    w_load = {{16{w_half[15]}}, w_half};
            3'd5:    w_load = {16'd0, w_half};
            3'd2:    w_load = w_word;
            default: w_load = 32'd0;
        endcase
        if (req_write || w_err) begin
            w_rdata_next = 32'd0;
        end else begin
            w_rdata_next = w_load;
        end
    end

    // Next-state logic for the IDLE -> (WAIT) -> RESP handshake sequence.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (READ_LATENCY > 32'd1) begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = WAIT_INIT;
                    end else begin
                        w_state_next = S_RESP;
                    end
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_state_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 2'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_RESP;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 2'd0;
            end
        endcase
    end

    // State register plus response capture at the accept edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_rdata <= 32'd0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_rdata <= w_rdata_next;
                r_error <= w_err;
            end
        end
    end

    generate
        if (CLEAR_ON_RESET) begin : g_clear
            // Array with reset clear; stores commit on the accept edge.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                        r_mem[i] <= 32'd0;
                    end
                end else if (w_write_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_wmask[b]) begin
                            r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end else begin : g_keep
            // Array contents survive reset; stores commit on the accept edge.
            always_ff @(posedge clk) begin
                if (w_write_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_wmask[b]) begin
                            r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

endmodule
